// File: rtl/powerup_sprite_engine.sv
// ============================================================================
// Module      : powerup_sprite_engine
// Description : Power-up sprite life cycle (spawn/active/blink/collect) and
//               2-cycle palette overlay on the pixel stream from bitmap RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module powerup_sprite_engine #(
  parameter int              CD             = 12,
  parameter int              ADDR_WIDTH     = 8,
  parameter logic [CD-1:0]   PAL1           = 12'hF80,
  parameter logic [CD-1:0]   PAL2           = 12'hFF0,
  parameter logic [CD-1:0]   PAL3           = 12'h000,
  parameter logic [CD-1:0]   FLASH_COLOR    = 12'hFFF,
  parameter int              BLINK_FRAMES   = 120,
  parameter int              COLLECT_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_tick,
  input  logic                  cmd_spawn,
  input  logic [10:0]           spawn_x,
  input  logic [10:0]           spawn_y,
  input  logic [15:0]           spawn_life,
  input  logic                  cmd_collect,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [1:0]            rom_data,
  input  logic [CD-1:0]         si_rgb,
  output logic [CD-1:0]         so_rgb,
  output logic                  active,
  output logic                  collected,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_BLINK   = 2'd2,
    S_COLLECT = 2'd3
  } state_t;

  localparam logic [15:0] c_blink_lim   = 16'(BLINK_FRAMES);
  localparam logic [15:0] c_collect_cnt = 16'(COLLECT_FRAMES);

  state_t        r_state, w_state_n, w_state_c;
  logic          r_pend, w_pend_n;
  logic [10:0]   r_pend_x, r_pend_y, w_pend_x_n, w_pend_y_n;
  logic [15:0]   r_pend_life, w_pend_life_n;
  logic [10:0]   r_ox, r_oy, w_ox_n, w_oy_n;
  logic [15:0]   r_life, w_life_n, w_life_dec;
  logic [15:0]   r_flash, w_flash_n, w_flash_c;
  logic [3:0]    r_fcnt, w_fcnt_n;
  logic          r_collected, w_collected_n;

  assign w_life_dec = r_life - 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pend      <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_life <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_life      <= '0;
      r_flash     <= '0;
      r_fcnt      <= '0;
      r_collected <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pend      <= w_pend_n;
      r_pend_x    <= w_pend_x_n;
      r_pend_y    <= w_pend_y_n;
      r_pend_life <= w_pend_life_n;
      r_ox        <= w_ox_n;
      r_oy        <= w_oy_n;
      r_life      <= w_life_n;
      r_flash     <= w_flash_n;
      r_fcnt      <= w_fcnt_n;
      r_collected <= w_collected_n;
    end
  end

  // Collect resolves first; frame_tick then acts on the post-collect state.
  always_comb begin
    w_state_c     = r_state;
    w_flash_c     = r_flash;
    w_collected_n = 1'b0;
    w_pend_n      = r_pend;
    w_pend_x_n    = r_pend_x;
    w_pend_y_n    = r_pend_y;
    w_pend_life_n = r_pend_life;
    w_ox_n        = r_ox;
    w_oy_n        = r_oy;
    w_life_n      = r_life;
    w_fcnt_n      = r_fcnt;

    if (cmd_collect && (r_state == S_ACTIVE || r_state == S_BLINK)) begin
      w_state_c     = S_COLLECT;
      w_flash_c     = c_collect_cnt;
      w_collected_n = 1'b1;
    end
    w_state_n = w_state_c;
    w_flash_n = w_flash_c;

    if (frame_tick) begin
      w_fcnt_n = r_fcnt + 4'd1;
      if (r_pend) begin
        w_ox_n   = r_pend_x;
        w_oy_n   = r_pend_y;
        w_life_n = r_pend_life;
        w_pend_n = 1'b0;
        if (r_pend_life <= c_blink_lim) begin
          w_state_n = S_BLINK;
          w_fcnt_n  = 4'd0;
        end else begin
          w_state_n = S_ACTIVE;
        end
      end else begin
        case (w_state_c)
          S_ACTIVE, S_BLINK: begin
            w_life_n = w_life_dec;
            if (w_life_dec == 16'd0) begin
              w_state_n = S_IDLE;
            end else if (w_life_dec <= c_blink_lim) begin
              w_state_n = S_BLINK;
              if (w_state_c == S_ACTIVE) w_fcnt_n = 4'd0;
            end
          end
          S_COLLECT: begin
            w_flash_n = w_flash_c - 16'd1;
            if (w_flash_n == 16'd0) w_state_n = S_IDLE;
          end
          default: ;
        endcase
      end
    end

    // A same-cycle spawn lands after the tick's pending consume.
    if (cmd_spawn && spawn_life != 16'd0) begin
      w_pend_n      = 1'b1;
      w_pend_x_n    = spawn_x;
      w_pend_y_n    = spawn_y;
      w_pend_life_n = spawn_life;
    end
  end

  assign state     = r_state;
  assign active    = (r_state == S_ACTIVE) || (r_state == S_BLINK);
  assign collected = r_collected;

  // Pixel path: address in cycle n, RAM data and aligned side-band in n+1.
  logic [3:0]    w_dx, w_dy;
  logic [11:0]   w_x12, w_y12, w_ox12, w_oy12;
  logic          w_in_region, w_draw_en;
  logic          r_in_region_d, r_draw_en_d, r_flash_d;
  logic [CD-1:0] r_si_rgb_d, r_so_rgb, w_overlay;

  assign w_dx     = x[3:0] - r_ox[3:0];
  assign w_dy     = y[3:0] - r_oy[3:0];
  assign rom_addr = ADDR_WIDTH'({w_dy, w_dx});

  assign w_x12  = {1'b0, x};
  assign w_y12  = {1'b0, y};
  assign w_ox12 = {1'b0, r_ox};
  assign w_oy12 = {1'b0, r_oy};
  assign w_in_region = (w_x12 >= w_ox12) && (w_x12 <= w_ox12 + 12'd15) &&
                       (w_y12 >= w_oy12) && (w_y12 <= w_oy12 + 12'd15);

  assign w_draw_en = (r_state == S_ACTIVE) || (r_state == S_COLLECT) ||
                     ((r_state == S_BLINK) && !r_fcnt[3]);

  always_comb begin
    w_overlay = '0;
    case (rom_data)
      2'd1:    w_overlay = PAL1;
      2'd2:    w_overlay = PAL2;
      2'd3:    w_overlay = PAL3;
      default: w_overlay = '0;
    endcase
    if (r_flash_d) w_overlay = FLASH_COLOR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_region_d <= 1'b0;
      r_draw_en_d   <= 1'b0;
      r_flash_d     <= 1'b0;
      r_si_rgb_d    <= '0;
      r_so_rgb      <= '0;
    end else begin
      r_in_region_d <= w_in_region;
      r_draw_en_d   <= w_draw_en;
      r_flash_d     <= (r_state == S_COLLECT);
      r_si_rgb_d    <= si_rgb;
      r_so_rgb      <= (r_in_region_d && r_draw_en_d && rom_data != 2'd0) ?
                       w_overlay : r_si_rgb_d;
    end
  end

  assign so_rgb = r_so_rgb;

endmodule

`default_nettype wire
